adder_response_checker: RTL and testbench
=========================================

// Module: adder_response_checker
// PURPOSE
//  Self-checking monitor for WIDTH-bit ripple/dataflow full adders.
//  Accepts one {a,b,c_in,sum,cout} vector per handshake and recomputes a+b+c_in.
//  Counts passes/fails and records the first failing vector.
//  Sits downstream of the adder DUT in on-chip BIST and simulation benches.
// PARAMETERS
//  WIDTH  4  operand/sum width in bits
//  CNT_W  8  pass/fail counter width
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous reset, active low
//  start         in   1        pulse: IDLE->RUN
//  clear         in   1        pulse: counters/flags cleared, ->IDLE
//  in_valid      in   1        vector present
//  in_ready      out  1        checker can accept
//  a, b          in   WIDTH    DUT operands
//  c_in          in   1        DUT carry in
//  sum           in   WIDTH    DUT sum
//  cout          in   1        DUT carry out
//  chk_valid     out  1        1-cycle pulse: result of one vector
//  chk_pass      out  1        qualified by chk_valid
//  pass_cnt      out  CNT_W    passing vectors, saturating
//  fail_cnt      out  CNT_W    failing vectors, saturating
//  err_flag      out  1        sticky: any fail since clear
//  ff_a, ff_b    out  WIDTH    first failing operands
//  ff_cin        out  1        first failing carry in
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; every output 0.
//  - FSM: IDLE -start-> RUN; RUN -clear-> IDLE; HALT -clear-> IDLE.
//    clear beats start in the same cycle. start while RUN/HALT is ignored.
//  - in_ready=1 only in RUN. Accept = in_valid & in_ready.
//  - Inputs are sampled on accept. Expected = a+b+c_in, computed WIDTH+1 bits wide.
//    Compare against {cout,sum}. All WIDTH+1 bits must match.
//  - Latency: chk_valid/chk_pass registered, 1 cycle after accept.
//    pass_cnt/fail_cnt/err_flag update in that same cycle.
//  - Back-to-back accepts allowed, giving 1 result per cycle.
//  - Counters saturate at 2**CNT_W-1 and do not wrap.
//  - First fail: ff_a/ff_b/ff_cin are loaded only when err_flag is 0.
//    They are held until clear or reset.
//  - clear: counters, err_flag and ff_* go to 0 on the next edge.
//    An in-flight result in that cycle is discarded: chk_valid=0.
//  - Entering IDLE from RUN mid-stream drops nothing already accepted.
//    The pending result still emits unless a clear occurs.
//  - Async reset mid-operation aborts with no result emitted.
// CONFIGURATION
//  CHK_STOP_ON_FAIL_EN defined:
//    - First fail moves RUN->HALT in the same cycle as chk_valid.
//    - in_ready=0 in HALT until clear.
//    - A vector accepted in the cycle the fail result appears is still checked.
//  CHK_STOP_ON_FAIL_EN undefined:
//    - HALT is unreachable; checker keeps running after fails.
//    - err_flag stays sticky.
// TESTING
//  1. After reset, a=2 b=2 c_in=1 sum=5 cout=0 held valid without start:
//     in_ready=0, no chk_valid.
//  2. start, then vectors 0+0+0=0/0, 2+2+1=5/0, 7+7+1=15/0, 8+7+1=0/1:
//     4 chk_pass pulses, pass_cnt=4, fail_cnt=0, err_flag=0.
//  3. a=5 b=7 c_in=0 sum=11 cout=0 (exp 12):
//     chk_pass=0, fail_cnt=1, err_flag=1, ff_a=5 ff_b=7 ff_cin=0.
//     A later fail (a=1 b=1 sum=3) leaves ff_* unchanged.
//  4. CNT_W=2, 5 passing vectors back-to-back:
//     chk_valid high 5 consecutive cycles, pass_cnt stays 3.
//  5. With CHK_STOP_ON_FAIL_EN, a fail then more valid vectors:
//     in_ready=0, fail_cnt=1. After clear+start, counters are 0 and accepts resume.
//  6. rst_n low 1 cycle after an accept: no chk_valid, all outputs 0, state IDLE.

Source files
------------

// File: rtl/adder_response_checker.sv
// Response checker for WIDTH-bit adders: recomputes a+b+c_in per accepted
// vector, counts pass/fail and latches the first failing vector.
// Optional build macro: CHK_STOP_ON_FAIL_EN (halt intake after a fail).
module adder_response_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_flag,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_cin
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_next;

    logic             accept;
    logic [WIDTH:0]   exp_sum;
    logic [WIDTH:0]   got_sum;
    logic             match;

    assign in_ready = (state == RUN);
    assign accept   = in_valid & in_ready;

    assign exp_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    assign got_sum = {cout, sum};
    assign match   = (exp_sum == got_sum);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: clear always wins; start only acts from IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = IDLE;
                end
`ifdef CHK_STOP_ON_FAIL_EN
                else if (chk_valid && !chk_pass) begin
                    state_next = HALT;
                end
`endif
            end
            HALT: begin
                if (clear) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result, counters and first-fail capture; clear discards an in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            err_flag  <= 1'b0;
            ff_a      <= '0;
            ff_b      <= '0;
            ff_cin    <= 1'b0;
        end else if (clear) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            err_flag  <= 1'b0;
            ff_a      <= '0;
            ff_b      <= '0;
            ff_cin    <= 1'b0;
        end else begin
            chk_valid <= accept;
            chk_pass  <= accept & match;
            if (accept) begin
                if (match) begin
                    if (pass_cnt != CNT_MAX) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end else begin
                    if (fail_cnt != CNT_MAX) begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                    err_flag <= 1'b1;
                    if (!err_flag) begin
                        ff_a   <= a;
                        ff_b   <= b;
                        ff_cin <= c_in;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker: a CNT_W=8 instance and a
// CNT_W=2 instance share stimulus; the small one exercises saturation.
module tb_adder_response_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] sum;
    logic       cout;

    logic       in_ready;
    logic       chk_valid;
    logic       chk_pass;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
    logic       err_flag;
    logic [3:0] ff_a;
    logic [3:0] ff_b;
    logic       ff_cin;

    logic       in_ready2;
    logic       chk_valid2;
    logic       chk_pass2;
    logic [1:0] pass_cnt2;
    logic [1:0] fail_cnt2;
    logic       err_flag2;
    logic [3:0] ff_a2;
    logic [3:0] ff_b2;
    logic       ff_cin2;

    int passed;
    int total;

    adder_response_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sum(sum), .cout(cout),
        .chk_valid(chk_valid), .chk_pass(chk_pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag),
        .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin)
    );

    adder_response_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c_in(c_in), .sum(sum), .cout(cout),
        .chk_valid(chk_valid2), .chk_pass(chk_pass2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .err_flag(err_flag2),
        .ff_a(ff_a2), .ff_b(ff_b2), .ff_cin(ff_cin2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input logic [3:0] va, input logic [3:0] vb,
                       input logic vc, input logic [3:0] vs,
                       input logic vco);
        a    = va;
        b    = vb;
        c_in = vc;
        sum  = vs;
        cout = vco;
    endtask

    logic [3:0] t4_a [5];
    logic [3:0] t4_s [5];
    logic [7:0] t4_big [5];
    logic [1:0] t4_small [5];

    initial begin
        passed = 0;
        total  = 0;
        t4_a     = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        t4_s     = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        t4_big   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        t4_small = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n    = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        vec(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_chk_valid", chk_valid, 0);
        check("rst_chk_pass", chk_pass, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_ff", {ff_a, ff_b, ff_cin}, 0);
        check("rst_in_ready", in_ready, 0);

        // 1: valid vector held without start is never taken
        vec(4'd2, 4'd2, 1'b1, 4'd5, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_in_ready", in_ready, 0);
            check("idle_chk_valid", chk_valid, 0);
        end

        // 2: four passing vectors, including full carry out
        in_valid = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("run_in_ready", in_ready, 1);
        in_valid = 1'b1;
        vec(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        check("p0_valid", chk_valid, 1);
        check("p0_pass", chk_pass, 1);
        check("p0_cnt", pass_cnt, 1);
        vec(4'd2, 4'd2, 1'b1, 4'd5, 1'b0);
        step();
        check("p1_valid", chk_valid, 1);
        check("p1_pass", chk_pass, 1);
        vec(4'd7, 4'd7, 1'b1, 4'd15, 1'b0);
        step();
        check("p2_valid", chk_valid, 1);
        check("p2_pass", chk_pass, 1);
        vec(4'd8, 4'd7, 1'b1, 4'd0, 1'b1);
        step();
        check("p3_valid", chk_valid, 1);
        check("p3_pass", chk_pass, 1);
        in_valid = 1'b0;
        step();
        check("p_idle_valid", chk_valid, 0);
        check("p_pass_cnt", pass_cnt, 4);
        check("p_fail_cnt", fail_cnt, 0);
        check("p_err_flag", err_flag, 0);

        // 3: first fail captured, later fail leaves capture alone
        in_valid = 1'b1;
        vec(4'd5, 4'd7, 1'b0, 4'd11, 1'b0);
        step();
        check("f0_valid", chk_valid, 1);
        check("f0_pass", chk_pass, 0);
        check("f0_fail_cnt", fail_cnt, 1);
        check("f0_err", err_flag, 1);
        check("f0_ff_a", ff_a, 5);
        check("f0_ff_b", ff_b, 7);
        check("f0_ff_cin", ff_cin, 0);
        check("f0_in_ready", in_ready, 1);
        vec(4'd1, 4'd1, 1'b0, 4'd3, 1'b0);
        step();
        check("f1_valid", chk_valid, 1);
        check("f1_pass", chk_pass, 0);
        check("f1_fail_cnt", fail_cnt, 2);
        check("f1_ff_a", ff_a, 5);
        check("f1_ff_b", ff_b, 7);
        check("f1_pass_cnt", pass_cnt, 4);
        in_valid = 1'b0;
        step();
        check("f_idle_valid", chk_valid, 0);
        check("f_err_sticky", err_flag, 1);
`ifdef CHK_STOP_ON_FAIL_EN
        check("f_halt_ready", in_ready, 0);
`else
        check("f_run_ready", in_ready, 1);
`endif

        // clear with a simultaneous accept discards the result
        in_valid = 1'b1;
        vec(4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
        clear = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", chk_valid, 0);
        check("clr_pass_cnt", pass_cnt, 0);
        check("clr_fail_cnt", fail_cnt, 0);
        check("clr_err", err_flag, 0);
        check("clr_ff", {ff_a, ff_b, ff_cin}, 0);
        check("clr_in_ready", in_ready, 0);

        // clear beats start
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        check("clr_beats_start", in_ready, 0);

        // 4: back-to-back passes, small counter saturates at 3
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vec(t4_a[i], 4'd1, 1'b0, t4_s[i], 1'b0);
            step();
            check("b2b_valid", chk_valid2, 1);
            check("b2b_pass", chk_pass2, 1);
            check("b2b_cnt_small", pass_cnt2, t4_small[i]);
            check("b2b_cnt_big", pass_cnt, t4_big[i]);
        end
        in_valid = 1'b0;
        step();
        check("sat_hold", pass_cnt2, 3);
        check("sat_valid_low", chk_valid2, 0);

        // 5: fail behaviour on continued stimulus
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        vec(4'd3, 4'd3, 1'b0, 4'd7, 1'b0);
        step();
        check("s_fail_valid", chk_valid, 1);
        check("s_fail_pass", chk_pass, 0);
        check("s_fail_ready", in_ready, 1);
        vec(4'd1, 4'd2, 1'b0, 4'd3, 1'b0);
        step();
        check("s_late_valid", chk_valid, 1);
        check("s_late_pass", chk_pass, 1);
        check("s_late_cnt", pass_cnt, 1);
`ifdef CHK_STOP_ON_FAIL_EN
        check("s_halt_ready", in_ready, 0);
        step();
        check("s_halt_valid", chk_valid, 0);
        check("s_halt_fail", fail_cnt, 1);
        check("s_halt_pass", pass_cnt, 1);
        in_valid = 1'b0;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("s_resume_pass", pass_cnt, 0);
        check("s_resume_fail", fail_cnt, 0);
        check("s_resume_ready", in_ready, 1);
        in_valid = 1'b1;
        step();
        check("s_resume_valid", chk_valid, 1);
        check("s_resume_cnt", pass_cnt, 1);
`else
        check("s_run_ready", in_ready, 1);
        step();
        check("s_run_valid", chk_valid, 1);
        check("s_run_fail", fail_cnt, 1);
        check("s_run_pass", pass_cnt, 2);
`endif

        // 6: async reset right after an accept
        vec(4'd4, 4'd4, 1'b1, 4'd9, 1'b0);
        in_valid = 1'b1;
        step();
        check("r_pre_valid", chk_valid, 1);
        rst_n = 1'b0;
        #1;
        check("r_valid", chk_valid, 0);
        check("r_pass", chk_pass, 0);
        check("r_cnts", {pass_cnt, fail_cnt}, 0);
        check("r_err", err_flag, 0);
        check("r_ff", {ff_a, ff_b, ff_cin}, 0);
        check("r_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        check("r_post_ready", in_ready, 0);
        check("r_post_valid", chk_valid, 0);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
